audio_dsp_pipeline: RTL
=======================

// Module: audio_dsp_pipeline
// PURPOSE
//  Parametrised successor of the single-width audio DSP subsystem. It takes one signed sample per
//  handshake and runs it through an N-tap FIR and/or a feedback echo, selected per sample.
//  It returns one result with fixed latency. It sits between the audio codec sample source
//  and the codec output path.
// PARAMETERS
//  W           16    sample width, signed two's complement; coefficients are Q1.(W-1)
//  TAPS        8     FIR tap count (>=2)
//  ECHO_DEPTH  1024  echo delay in samples, power of two (>=4)
//  ECHO_SHIFT  1     echo attenuation, arithmetic right shift of the delayed sample
// PORTS
//  clk               in   1        system clock
//  reset             in   1        asynchronous, active-high reset
//  signal            in   W        input sample
//  signal_valid      in   1        input sample present
//  signal_ready      out  1        block can accept a sample (high only in IDLE)
//  select            in   2        00 bypass, 01 FIR, 10 echo, 11 FIR then echo
//  signal_output     out  W        result sample
//  signal_out_valid  out  1        one-cycle strobe: signal_output is new
// BEHAVIOUR
//  - Reset values: signal_output=0, signal_out_valid=0, signal_ready=0, tap history=0, FSM=CLEAR.
//  - FSM states and transitions:
//    - CLEAR: walks ECHO_DEPTH cycles writing 0 to the echo buffer, then goes to IDLE.
//    - IDLE: ready=1. On signal_valid&&signal_ready, latch signal and latch select into sel_q.
//      Shift the sample into the TAPS-deep history and go to MAC.
//    - MAC: TAPS cycles, one coefficient*history product accumulated per cycle.
//      The accumulator is 2W+clog2(TAPS) bits wide.
//    - ECHO: one cycle, computes the echo stage (rules below).
//    - OUT: registers signal_output, pulses signal_out_valid, returns to IDLE.
//  - Latency: signal_out_valid is high exactly TAPS+2 clocks after the accepting edge.
//    The latency is identical in every mode. Minimum sample spacing is TAPS+3 clocks.
//  - FIR result: f = sat(acc >>> (W-1)).
//  - Echo stage:
//    - e_in = f if sel_q==11, else the raw sample.
//    - d = buf[ptr]; y = sat(e_in + (d >>> ECHO_SHIFT)).
//    - buf[ptr] <= y; ptr <= ptr+1, wrapping modulo ECHO_DEPTH.
//    - The buffer and pointer update on every sample in every mode, so echo state stays continuous.
//  - Output: 00 -> raw sample, 01 -> f, 10/11 -> y.
//  - signal_valid while signal_ready=0 is ignored. Upstream must hold the sample until accepted.
//  - A select change mid-sample has no effect until the next accept.
//  - Reset mid-operation aborts the sample: no strobe, history cleared, CLEAR re-runs.
//  - sat() clamps to [-2^(W-1), 2^(W-1)-1]; sat() behaviour is defined by CONFIGURATION.
// CONFIGURATION
//  DSP_SAT_EN defined:   every sat() clamps to the signed W-bit range.
//  DSP_SAT_EN undefined: sat() truncates to the low W bits (two's-complement wrap).
//                        This mode has no clamp logic.
// STRUCTURE
//  - Package dsp_pkg holds:
//    - mode constants MODE_BYPASS/MODE_FIR/MODE_ECHO/MODE_FIR_ECHO;
//    - the FSM state enum;
//    - function fir_coef(i, TAPS): default moving average, each coefficient 2^(W-1)/TAPS.
//  - Sub-module echo_delay_line holds the circular buffer and pointer and provides:
//    - clear walk with a done flag;
//    - combinational read of buf[ptr];
//    - a write-and-advance strobe.
//  - The FSM, history and MAC live in the top.
// TESTING
//  (TAPS=4, ECHO_DEPTH=8, ECHO_SHIFT=1, W=16, samples spaced 7 clocks)
//  1. Reset release -> ready stays 0 for 8 clocks, then goes 1; outputs stay 0.
//     Assert reset mid-MAC -> no strobe is produced.
//  2. select=01, impulse 0x4000 then zeros -> outputs 0x1000 x4, then 0x0000.
//     Each strobe lands exactly 6 clocks after its accept.
//  3. select=10, impulse 0x4000 then zeros -> output 0x4000 at sample 0, 0x2000 at 8,
//     0x1000 at 16, 0x0800 at 24, 0 elsewhere.
//  4. select=11, impulse 0x4000 -> 0x1000 x4, then 0x0800 x4 starting at sample 8.
//  5. select=10, constant 0x7000 -> sample 8 gives 0x7FFF with DSP_SAT_EN, 0xA800 without.
//  6. Hold signal_valid through busy cycles, and toggle select during MAC.
//     -> exactly one accept per IDLE; each output uses the select latched at its accept;
//     select=00 output equals the input sample.

Source files
------------

// File: rtl/dsp_pkg.sv
// rtl/dsp_pkg.sv - shared mode constants, FSM states and default FIR coefficients
package dsp_pkg;

    localparam logic [1:0] MODE_BYPASS   = 2'b00;
    localparam logic [1:0] MODE_FIR      = 2'b01;
    localparam logic [1:0] MODE_ECHO     = 2'b10;
    localparam logic [1:0] MODE_FIR_ECHO = 2'b11;

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_MAC,
        ST_ECHO,
        ST_OUT
    } dsp_state_t;

    // Moving average in Q1.(w-1): every tap weighs 1/taps.
    function automatic longint fir_coef(input int i, input int taps, input int w = 16);
        if (i < 0 || i >= taps) begin
            return 0;
        end
        return (longint'(1) << (w - 1)) / longint'(taps);
    endfunction

endpackage

// File: rtl/echo_delay_line.sv
// rtl/echo_delay_line.sv - circular echo buffer with clear walk and write-and-advance pointer
module echo_delay_line #(
    parameter int W     = 16,
    parameter int DEPTH = 1024
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                clr,
    input  logic                wr_en,
    input  logic signed [W-1:0] wr_data,
    output logic                clr_done,
    output logic signed [W-1:0] rd_data
);

    localparam int PTR_W = $clog2(DEPTH);

    logic signed [W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]    ptr;

    assign rd_data  = mem[ptr];
    // The clear walk reuses the sample pointer, so it ends wrapped back at slot 0.
    assign clr_done = clr && (&ptr);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr <= '0;
        end else if (clr || wr_en) begin
            ptr <= ptr + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            mem[ptr] <= '0;
        end else if (wr_en) begin
            mem[ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/audio_dsp_pipeline.sv
// rtl/audio_dsp_pipeline.sv - sample-serial FIR and feedback echo; DSP_SAT_EN selects clamping over wrap
module audio_dsp_pipeline
    import dsp_pkg::*;
#(
    parameter int W          = 16,
    parameter int TAPS       = 8,
    parameter int ECHO_DEPTH = 1024,
    parameter int ECHO_SHIFT = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic signed [W-1:0] signal,
    input  logic                signal_valid,
    output logic                signal_ready,
    input  logic [1:0]          select,
    output logic signed [W-1:0] signal_output,
    output logic                signal_out_valid
);

    localparam int ACC_W = 2 * W + $clog2(TAPS);
    localparam int CNT_W = $clog2(TAPS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TAPS - 1);

    function automatic logic signed [ACC_W-1:0] sext(input logic signed [W-1:0] v);
        return {{(ACC_W - W){v[W-1]}}, v};
    endfunction

    function automatic logic signed [W-1:0] sat(input logic signed [ACC_W-1:0] v);
`ifdef DSP_SAT_EN
        logic signed [W-1:0] hi;
        logic signed [W-1:0] lo;
        hi = {1'b0, {(W - 1){1'b1}}};
        lo = {1'b1, {(W - 1){1'b0}}};
        if (v > sext(hi)) begin
            return hi;
        end else if (v < sext(lo)) begin
            return lo;
        end else begin
            return W'(v);
        end
`else
        return W'(v);
`endif
    endfunction

    dsp_state_t              state;
    logic [1:0]              sel_q;
    logic [CNT_W-1:0]        cnt;
    logic signed [W-1:0]     sample_q;
    logic signed [W-1:0]     res_q;
    logic signed [W-1:0]     hist [TAPS];
    logic signed [W-1:0]     coef [TAPS];
    logic signed [ACC_W-1:0] acc;

    logic signed [2*W-1:0]   mul_a;
    logic signed [2*W-1:0]   mul_b;
    logic signed [2*W-1:0]   prod;
    logic signed [ACC_W-1:0] fir_shift;
    logic signed [ACC_W-1:0] echo_sum;
    logic signed [W-1:0]     fir_res;
    logic signed [W-1:0]     echo_in;
    logic signed [W-1:0]     echo_d;
    logic signed [W-1:0]     echo_res;
    logic                    clr;
    logic                    clr_done;
    logic                    echo_wr;

    for (genvar g = 0; g < TAPS; g++) begin : g_coef
        assign coef[g] = W'(fir_coef(g, TAPS, W));
    end

    always_comb begin
        mul_a     = {{W{hist[cnt][W-1]}}, hist[cnt]};
        mul_b     = {{W{coef[cnt][W-1]}}, coef[cnt]};
        prod      = mul_a * mul_b;
        fir_shift = acc >>> (W - 1);
        fir_res   = sat(fir_shift);
        echo_in   = (sel_q == MODE_FIR_ECHO) ? fir_res : sample_q;
        echo_sum  = sext(echo_in) + sext(echo_d >>> ECHO_SHIFT);
        echo_res  = sat(echo_sum);
    end

    assign clr     = (state == ST_CLEAR);
    assign echo_wr = (state == ST_ECHO);

    // Written on every sample regardless of mode so the echo tail stays continuous.
    echo_delay_line #(
        .W     (W),
        .DEPTH (ECHO_DEPTH)
    ) u_echo (
        .clk      (clk),
        .reset    (reset),
        .clr      (clr),
        .wr_en    (echo_wr),
        .wr_data  (echo_res),
        .clr_done (clr_done),
        .rd_data  (echo_d)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state            <= ST_CLEAR;
            signal_ready     <= 1'b0;
            signal_output    <= '0;
            signal_out_valid <= 1'b0;
            sel_q            <= MODE_BYPASS;
            cnt              <= '0;
            sample_q         <= '0;
            res_q            <= '0;
            acc              <= '0;
            for (int i = 0; i < TAPS; i++) begin
                hist[i] <= '0;
            end
        end else begin
            signal_out_valid <= 1'b0;
            case (state)
                ST_CLEAR: begin
                    if (clr_done) begin
                        state        <= ST_IDLE;
                        signal_ready <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (signal_valid && signal_ready) begin
                        sample_q     <= signal;
                        sel_q        <= select;
                        hist[0]      <= signal;
                        for (int i = 1; i < TAPS; i++) begin
                            hist[i] <= hist[i-1];
                        end
                        acc          <= '0;
                        cnt          <= '0;
                        signal_ready <= 1'b0;
                        state        <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    acc <= acc + {{(ACC_W - 2 * W){prod[2*W-1]}}, prod};
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) begin
                        state <= ST_ECHO;
                    end
                end
                ST_ECHO: begin
                    case (sel_q)
                        MODE_BYPASS:              res_q <= sample_q;
                        MODE_FIR:                 res_q <= fir_res;
                        MODE_ECHO, MODE_FIR_ECHO: res_q <= echo_res;
                        default:                  res_q <= sample_q;
                    endcase
                    state <= ST_OUT;
                end
                ST_OUT: begin
                    signal_output    <= res_q;
                    signal_out_valid <= 1'b1;
                    signal_ready     <= 1'b1;
                    state            <= ST_IDLE;
                end
                default: begin
                    state        <= ST_CLEAR;
                    signal_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule
